// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
package vend_pkg;

  localparam int CREDIT_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] Q_VAL = 7'd25;
  localparam logic [CREDIT_W-1:0] D_VAL = 7'd10;
  localparam logic [CREDIT_W-1:0] N_VAL = 7'd5;

endpackage

// File: rtl/change_pick.sv
// Greedy change selector: largest coin not exceeding the remaining credit.
module change_pick
  import vend_pkg::*;
(
  input  logic [CREDIT_W-1:0] credit,
  output logic                pick_q,
  output logic                pick_d,
  output logic                pick_n,
  output logic [CREDIT_W-1:0] pick_val
);

  always_comb begin
    pick_q   = 1'b0;
    pick_d   = 1'b0;
    pick_n   = 1'b0;
    pick_val = '0;
    if (credit >= Q_VAL) begin
      pick_q   = 1'b1;
      pick_val = Q_VAL;
    end else if (credit >= D_VAL) begin
      pick_d   = 1'b1;
      pick_val = D_VAL;
    end else if (credit >= N_VAL) begin
      pick_n   = 1'b1;
      pick_val = N_VAL;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending sequencer: coin accumulation, purchase, greedy change payout.
// Optional refund path enabled by defining VEND_CANCEL_EN.
//
// state  | meaning
// IDLE   | no credit, waiting for a coin
// ACCUM  | credit held, accepting coins / buy
// VEND   | item released this cycle; next edge pays first change coin
// CHANGE | paying out one coin per cycle until credit is exhausted
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE      = 65,
  parameter int CREDIT_MAX = 125
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_q,
  input  logic                coin_d,
  input  logic                coin_n,
  input  logic                buy,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                disp_q,
  output logic                disp_d,
  output logic                disp_n,
  output logic                coin_reject,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_SUM = (CREDIT_W + 1)'(CREDIT_MAX);

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic                vend_nx, disp_q_nx, disp_d_nx, disp_n_nx, reject_nx, busy_nx;

  logic                pick_q, pick_d, pick_n;
  logic [CREDIT_W-1:0] pick_val;
  logic [CREDIT_W-1:0] remain;

  logic                coin_any, coin_multi;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                buy_ok, cancel_ok;

  change_pick u_pick (
    .credit   (credit),
    .pick_q   (pick_q),
    .pick_d   (pick_d),
    .pick_n   (pick_n),
    .pick_val (pick_val)
  );

  assign coin_any   = coin_q | coin_d | coin_n;
  assign coin_multi = (coin_q & coin_d) | (coin_q & coin_n) | (coin_d & coin_n);
  assign coin_val   = coin_q ? Q_VAL : (coin_d ? D_VAL : (coin_n ? N_VAL : '0));
  // 8-bit sum so an overflowing coin is refused rather than wrapping
  assign coin_sum   = {1'b0, credit} + {1'b0, coin_val};
  assign remain     = credit - pick_val;
  assign buy_ok     = (state == ACCUM) && buy && (credit >= PRICE_C);

`ifdef VEND_CANCEL_EN
  assign cancel_ok  = (state == ACCUM) && cancel && !buy_ok;
`else
  assign cancel_ok  = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    vend_nx   = 1'b0;
    disp_q_nx = 1'b0;
    disp_d_nx = 1'b0;
    disp_n_nx = 1'b0;
    reject_nx = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (buy_ok) begin
          state_nx  = VEND;
          credit_nx = credit - PRICE_C;
          vend_nx   = 1'b1;
          reject_nx = coin_any;
        end else if (cancel_ok) begin
          state_nx  = CHANGE;
          reject_nx = coin_any;
        end else if (coin_any) begin
          if (coin_sum <= MAX_SUM) begin
            credit_nx = coin_sum[CREDIT_W-1:0];
            state_nx  = ACCUM;
            reject_nx = coin_multi;
          end else begin
            reject_nx = 1'b1;
          end
        end
      end
      VEND, CHANGE: begin
        reject_nx = coin_any;
        disp_q_nx = pick_q;
        disp_d_nx = pick_d;
        disp_n_nx = pick_n;
        // a residue below the smallest coin cannot be paid and is dropped
        if (remain < N_VAL) begin
          credit_nx = '0;
          state_nx  = IDLE;
        end else begin
          credit_nx = remain;
          state_nx  = CHANGE;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == VEND) || (state_nx == CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      vend        <= 1'b0;
      disp_q      <= 1'b0;
      disp_d      <= 1'b0;
      disp_n      <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      vend        <= vend_nx;
      disp_q      <= disp_q_nx;
      disp_d      <= disp_d_nx;
      disp_n      <= disp_n_nx;
      coin_reject <= reject_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed scoreboard bench for vend_ctrl (PRICE=65, CREDIT_MAX=125).
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_q, coin_d, coin_n, buy, cancel;
  logic [6:0] credit;
  logic       vend, disp_q, disp_d, disp_n, coin_reject, busy;

  // expected snapshot: {credit, vend, disp_q, disp_d, disp_n, coin_reject, busy}
  logic [12:0] sb[$];
  int          n_pass = 0;
  int          n_total = 0;

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_VEND = 6'b100001;
  localparam logic [5:0] F_DQ_B = 6'b010001;
  localparam logic [5:0] F_DD_B = 6'b001001;
  localparam logic [5:0] F_DD   = 6'b001000;
  localparam logic [5:0] F_DN   = 6'b000100;
  localparam logic [5:0] F_REJ  = 6'b000010;
  localparam logic [5:0] F_BUSY = 6'b000001;

  always #5 clk = ~clk;

  vend_ctrl #(.PRICE(65), .CREDIT_MAX(125)) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_q      (coin_q),
    .coin_d      (coin_d),
    .coin_n      (coin_n),
    .buy         (buy),
`ifdef VEND_CANCEL_EN
    .cancel      (cancel),
`endif
    .credit      (credit),
    .vend        (vend),
    .disp_q      (disp_q),
    .disp_d      (disp_d),
    .disp_n      (disp_n),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {credit, vend, disp_q, disp_d, disp_n, coin_reject, busy};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed credit=%0d flags=%b, expected credit=%0d flags=%b",
                tag, obs[12:6], obs[5:0], exp[12:6], exp[5:0]);
  endtask

  // drive one cycle of inputs, push the expected post-edge outputs, then compare
  task automatic step(input string tag, input logic [4:0] qdnbc, input int cr, input logic [5:0] fl);
    logic [12:0] exp;
    @(negedge clk);
    {coin_q, coin_d, coin_n, buy, cancel} = qdnbc;
    sb.push_back({7'(cr), fl});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    chk(tag, exp);
  endtask

  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_Q    = 5'b10000;
  localparam logic [4:0] I_D    = 5'b01000;
  localparam logic [4:0] I_N    = 5'b00100;
  localparam logic [4:0] I_BUY  = 5'b00010;
  localparam logic [4:0] I_CAN  = 5'b00001;

  initial begin
    reset = 1'b1;
    {coin_q, coin_d, coin_n, buy, cancel} = I_NONE;
    #12;
    chk("reset", 13'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: q,q,d,d then buy -> vend, one nickel change
    step("t1_q1", I_Q, 25, F_NONE);
    step("t1_q2", I_Q, 50, F_NONE);
    step("t1_d1", I_D, 60, F_NONE);
    step("t1_d2", I_D, 70, F_NONE);
    step("t1_buy", I_BUY, 5, F_VEND);
    step("t1_chg_n", I_NONE, 0, F_DN);
    step("t1_idle", I_NONE, 0, F_NONE);

    // buy with no credit is ignored
    step("idle_buy", I_BUY, 0, F_NONE);

    // 2: insufficient credit, then top-up and buy
    step("t2_q1", I_Q, 25, F_NONE);
    step("t2_q2", I_Q, 50, F_NONE);
    step("t2_buy_low", I_BUY, 50, F_NONE);
    step("t2_q3", I_Q, 75, F_NONE);
    step("t2_buy", I_BUY, 10, F_VEND);
    step("t2_chg_d", I_NONE, 0, F_DD);

    // exact price: vend with no change
    step("ex_q1", I_Q, 25, F_NONE);
    step("ex_q2", I_Q, 50, F_NONE);
    step("ex_d", I_D, 60, F_NONE);
    step("ex_n", I_N, 65, F_NONE);
    step("ex_buy", I_BUY, 0, F_VEND);
    step("ex_idle", I_NONE, 0, F_NONE);

    // 3: credit ceiling
    for (int i = 0; i < 4; i++) step("t3_q", I_Q, 25 * (i + 1), F_NONE);
    step("t3_d1", I_D, 110, F_NONE);
    step("t3_d2", I_D, 120, F_NONE);
    step("t3_q_rej", I_Q, 120, F_REJ);
    step("t3_n_fill", I_N, 125, F_NONE);
    step("t3_n_rej", I_N, 125, F_REJ);

    // 5a: 125 buy -> change 60 as q,q,d on consecutive cycles
    step("t5_buy", I_BUY, 60, F_VEND);
    step("t5_chg_q1", I_NONE, 35, F_DQ_B);
    step("t5_chg_q2", I_NONE, 10, F_DQ_B);
    step("t5_chg_d", I_NONE, 0, F_DD);
    step("t5_idle", I_NONE, 0, F_NONE);

    // 5b: reset after first change coin aborts payout
    for (int i = 0; i < 5; i++) step("t5b_q", I_Q, 25 * (i + 1), F_NONE);
    step("t5b_buy", I_BUY, 60, F_VEND);
    step("t5b_chg_q1", I_NONE, 35, F_DQ_B);
    #2 reset = 1'b1;
    #1 chk("t5b_rst_async", 13'd0);
    @(negedge clk);
    reset = 1'b0;
    step("t5b_after1", I_NONE, 0, F_NONE);
    step("t5b_after2", I_NONE, 0, F_NONE);

    // 4: simultaneous coins, coins during VEND/CHANGE
    step("t4_qd", I_Q | I_D, 25, F_REJ);
    step("t4_qdn", I_Q | I_D | I_N, 50, F_REJ);
    step("t4_q", I_Q, 75, F_NONE);
    step("t4_n", I_N, 80, F_NONE);
    step("t4_q2", I_Q, 105, F_NONE);
    step("t4_buy_coin", I_BUY | I_N, 40, F_VEND | F_REJ);
    step("t4_chg_q_coin", I_D, 15, F_DQ_B | F_REJ);
    step("t4_chg_d_coin", I_Q, 5, F_DD_B | F_REJ);
    step("t4_chg_n", I_NONE, 0, F_DN);
    step("t4_idle", I_NONE, 0, F_NONE);

`ifdef VEND_CANCEL_EN
    // 6: refund and buy-over-cancel
    step("t6_q", I_Q, 25, F_NONE);
    step("t6_d", I_D, 35, F_NONE);
    step("t6_n", I_N, 40, F_NONE);
    step("t6_cancel", I_CAN, 40, F_BUSY);
    step("t6_ref_q", I_NONE, 15, F_DQ_B);
    step("t6_ref_d", I_NONE, 5, F_DD_B);
    step("t6_ref_n", I_NONE, 0, F_DN);
    step("t6b_q1", I_Q, 25, F_NONE);
    step("t6b_q2", I_Q, 50, F_NONE);
    step("t6b_d", I_D, 60, F_NONE);
    step("t6b_n", I_N, 65, F_NONE);
    step("t6b_buy_can", I_BUY | I_CAN, 0, F_VEND);
    step("t6b_idle", I_NONE, 0, F_NONE);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
